// File: rtl/expand_load_arbiter_if.sv
// Bundle between the ExpandFSM array, the load arbiter and the DB fetch unit.
// slave = arbiter view, master = engine/memory (environment) view.
interface expand_load_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 512
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_load;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_loadDone;
    logic [NUM_REQ-1:0]        req_dataValid;
    logic [DATA_W-1:0]         req_data;
    logic                      mem_load;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_loadDone;
    logic                      mem_dataValid;
    logic [DATA_W-1:0]         mem_data;
    logic [GW-1:0]             grant_id;
    logic                      busy;
    logic                      timeout_err;

    modport slave (
        input  req_load, req_addr, mem_loadDone, mem_dataValid, mem_data,
        output req_loadDone, req_dataValid, req_data, mem_load, mem_addr,
               grant_id, busy, timeout_err
    );

    modport master (
        output req_load, req_addr, mem_loadDone, mem_dataValid, mem_data,
        input  req_loadDone, req_dataValid, req_data, mem_load, mem_addr,
               grant_id, busy, timeout_err
    );
endinterface

// File: rtl/expand_load_arbiter.sv
// Round-robin share of one DB load channel among NUM_REQ ExpandFSM engines.
// Latency: mem_load 1 cycle after grant; accept/data pulses 1 cycle after the memory strobe.
// Backpressure: one outstanding load; mem_load held until mem_loadDone. Option: LOAD_TIMEOUT_EN.
module expand_load_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    expand_load_arbiter_if.slave   bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RELEASE} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        ptr_q, ptr_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic                 mem_load_q, mem_load_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [NUM_REQ-1:0]   load_done_q, load_done_d;
    logic [NUM_REQ-1:0]   data_valid_q, data_valid_d;
    logic [DATA_W-1:0]    req_data_q, req_data_d;
    logic                 found;
    logic [GW-1:0]        pick;
    logic [GW:0]          idx;

`ifdef LOAD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 tmo_hit;
    logic                 timeout_err_q, timeout_err_d;
    assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        mem_load_d   = mem_load_q;
        mem_addr_d   = mem_addr_q;
        load_done_d  = '0;
        data_valid_d = '0;
        req_data_d   = req_data_q;
        found        = 1'b0;
        pick         = '0;
        idx          = '0;
`ifdef LOAD_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        // Scan from pointer+1 upward with wrap; first hit wins.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + (GW+1)'(k);
            if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
            if (!found && bus.req_load[idx[GW-1:0]]) begin
                found = 1'b1;
                pick  = idx[GW-1:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d    = pick;
                    ptr_d      = pick;
                    mem_addr_d = bus.req_addr[pick*ADDR_W +: ADDR_W];
                    mem_load_d = 1'b1;
                    state_d    = ISSUE;
`ifdef LOAD_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            ISSUE: begin
`ifdef LOAD_TIMEOUT_EN
                if (!tmo_hit) cnt_d = cnt_q + 1'b1;
`endif
                if (bus.mem_loadDone) begin
                    mem_load_d           = 1'b0;
                    load_done_d[grant_q] = 1'b1;
                    if (bus.mem_dataValid) begin
                        data_valid_d[grant_q] = 1'b1;
                        req_data_d            = bus.mem_data;
                        state_d               = RELEASE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
`ifdef LOAD_TIMEOUT_EN
                else if (tmo_hit) begin
                    // Counter stays saturated so WAIT_DATA times out on its first edge.
                    mem_load_d           = 1'b0;
                    load_done_d[grant_q] = 1'b1;
                    state_d              = WAIT_DATA;
                end
`endif
            end
            WAIT_DATA: begin
`ifdef LOAD_TIMEOUT_EN
                if (!tmo_hit) cnt_d = cnt_q + 1'b1;
`endif
                if (bus.mem_dataValid) begin
                    data_valid_d[grant_q] = 1'b1;
                    req_data_d            = bus.mem_data;
                    state_d               = RELEASE;
                end
`ifdef LOAD_TIMEOUT_EN
                else if (tmo_hit) begin
                    data_valid_d[grant_q] = 1'b1;
                    req_data_d            = '0;
                    timeout_err_d         = 1'b1;
                    state_d               = RELEASE;
                end
`endif
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            mem_load_q   <= 1'b0;
            mem_addr_q   <= '0;
            load_done_q  <= '0;
            data_valid_q <= '0;
            req_data_q   <= '0;
`ifdef LOAD_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            mem_load_q   <= mem_load_d;
            mem_addr_q   <= mem_addr_d;
            load_done_q  <= load_done_d;
            data_valid_q <= data_valid_d;
            req_data_q   <= req_data_d;
`ifdef LOAD_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign bus.req_loadDone  = load_done_q;
    assign bus.req_dataValid = data_valid_q;
    assign bus.req_data      = req_data_q;
    assign bus.mem_load      = mem_load_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.grant_id      = grant_q;
    assign bus.busy          = (state_q != IDLE);
`ifdef LOAD_TIMEOUT_EN
    assign bus.timeout_err   = timeout_err_q;
`else
    assign bus.timeout_err   = 1'b0;
`endif
endmodule

// File: tb/tb_expand_load_arbiter.sv
// Directed bench for expand_load_arbiter; expected grants/addresses queued at request time.
module tb_expand_load_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    expand_load_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    expand_load_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int             g;
        logic [AW-1:0]  a;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] oh(input int g);
        return NR'(1) << g;
    endfunction

    // Serves one load: waits for mem_load, holds off the accept for lat cycles, then returns d.
    task automatic serve(input int lat, input logic [DW-1:0] d, input bit same,
                         input bit drop, output int waited);
        exp_t e;
        waited = 0;
        while (bus.mem_load !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (bus.mem_load !== 1'b1) begin
            chk("mem_load_wait", {511'd0, bus.mem_load}, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard: grant %0d observed with no expectation queued", bus.grant_id);
            return;
        end
        e = exp_q.pop_front();
        chk("grant_id", bus.grant_id, e.g);
        chk("mem_addr", bus.mem_addr, e.a);
        repeat (lat) tick();
        chk("mem_load_held", bus.mem_load, 1);
        chk("mem_addr_held", bus.mem_addr, e.a);
        chk("early_loadDone", bus.req_loadDone, 0);
        bus.mem_loadDone = 1'b1;
        if (same) begin
            bus.mem_dataValid = 1'b1;
            bus.mem_data      = d;
        end
        tick();
        bus.mem_loadDone  = 1'b0;
        bus.mem_dataValid = 1'b0;
        if (drop) bus.req_load[e.g] = 1'b0;
        chk("req_loadDone", bus.req_loadDone, oh(e.g));
        chk("mem_load_low", bus.mem_load, 0);
        chk("req_dataValid_same", bus.req_dataValid, same ? oh(e.g) : '0);
        if (!same) begin
            tick();
            bus.mem_data      = d;
            bus.mem_dataValid = 1'b1;
            tick();
            bus.mem_dataValid = 1'b0;
            chk("req_dataValid", bus.req_dataValid, oh(e.g));
            chk("loadDone_once", bus.req_loadDone, 0);
        end
        chk("req_data", bus.req_data, d);
        chk("busy_release", bus.busy, 1);
        tick();
        chk("busy_idle", bus.busy, 0);
        chk("dataValid_once", bus.req_dataValid, 0);
    endtask

    initial begin
        int w;
        int n;
        rst               = 1'b1;
        bus.req_load      = '0;
        bus.req_addr      = '0;
        bus.mem_loadDone  = 1'b0;
        bus.mem_dataValid = 1'b0;
        bus.mem_data      = '0;
        repeat (3) tick();

        chk("rst_mem_load", bus.mem_load, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_loadDone", bus.req_loadDone, 0);
        chk("rst_dataValid", bus.req_dataValid, 0);
        chk("rst_req_data", bus.req_data, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        rst = 1'b0;
        tick();

        // Round robin over engines 0,1,3 with requests held; engine 2 silent.
        bus.req_addr[0*AW +: AW] = 32'h10;
        bus.req_addr[1*AW +: AW] = 32'h20;
        bus.req_addr[2*AW +: AW] = 32'h30;
        bus.req_addr[3*AW +: AW] = 32'h40;
        bus.req_load = 4'b1011;
        exp_q.push_back('{0, 32'h10});
        exp_q.push_back('{1, 32'h20});
        exp_q.push_back('{3, 32'h40});
        exp_q.push_back('{0, 32'h10});
        serve(2, 512'h100, 1'b0, 1'b0, w);
        serve(1, 512'h101, 1'b0, 1'b0, w);
        serve(0, 512'h103, 1'b0, 1'b0, w);
        serve(4, 512'h104, 1'b0, 1'b0, w);
        bus.req_load = '0;
        tick();
        chk("rr_idle_after_drop", bus.busy, 0);

        // Single request, engine 0 at 0x28.
        bus.req_addr[0*AW +: AW] = 32'h28;
        bus.req_load = 4'b0001;
        exp_q.push_back('{0, 32'h28});
        serve(3, 512'hfff, 1'b0, 1'b1, w);
        chk("t1_grant_latency", w, 1);

        // Accept and data on the same edge.
        bus.req_load = 4'b0100;
        exp_q.push_back('{2, 32'h30});
        serve(1, 512'h3333, 1'b1, 1'b1, w);

        // Stray memory strobes while idle.
        bus.mem_data      = 512'habc;
        bus.mem_dataValid = 1'b1;
        bus.mem_loadDone  = 1'b1;
        repeat (2) begin
            tick();
            chk("stray_dataValid", bus.req_dataValid, 0);
            chk("stray_loadDone", bus.req_loadDone, 0);
            chk("stray_req_data", bus.req_data, 512'h3333);
            chk("stray_busy", bus.busy, 0);
        end
        bus.mem_dataValid = 1'b0;
        bus.mem_loadDone  = 1'b0;
        tick();

        // Reset during WAIT_DATA abandons the load.
        bus.req_load = 4'b0001;
        n = 0;
        while (bus.mem_load !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_grant", bus.grant_id, 0);
        chk("t4_mem_addr", bus.mem_addr, 32'h28);
        bus.mem_loadDone = 1'b1;
        tick();
        bus.mem_loadDone = 1'b0;
        bus.req_load     = '0;
        chk("t4_loadDone", bus.req_loadDone, oh(0));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_mem_load", bus.mem_load, 0);
        chk("t4_mem_addr_rst", bus.mem_addr, 0);
        chk("t4_dataValid", bus.req_dataValid, 0);
        chk("t4_req_data", bus.req_data, 0);
        chk("t4_grant_rst", bus.grant_id, 0);
        chk("t4_busy", bus.busy, 0);
        bus.mem_data      = 512'h555;
        bus.mem_dataValid = 1'b1;
        tick();
        bus.mem_dataValid = 1'b0;
        chk("t4_late_dataValid", bus.req_dataValid, 0);
        chk("t4_late_req_data", bus.req_data, 0);
        bus.req_load = 4'b1001;
        exp_q.push_back('{0, 32'h28});
        serve(1, 512'h777, 1'b0, 1'b1, w);
        bus.req_load = '0;
        tick();

`ifdef LOAD_TIMEOUT_EN
        // Memory never accepts: timeout path.
        bus.req_load = 4'b0010;
        n = 0;
        while (bus.mem_load !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t6_grant", bus.grant_id, 1);
        n = 0;
        while (bus.req_loadDone === '0 && n < 40) begin
            tick();
            n++;
        end
        bus.req_load = '0;
        chk("t6_loadDone", bus.req_loadDone, oh(1));
        chk("t6_cycles", n, 16);
        chk("t6_mem_load", bus.mem_load, 0);
        tick();
        chk("t6_dataValid", bus.req_dataValid, oh(1));
        chk("t6_req_data", bus.req_data, 0);
        chk("t6_timeout_err", bus.timeout_err, 1);
        repeat (3) tick();
        chk("t6_sticky", bus.timeout_err, 1);
        chk("t6_busy", bus.busy, 0);
`endif

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
